// File: rtl/avoidance_sequencer.sv
// avoidance_sequencer
// Obstacle-avoidance motion sequencer. It reads range samples from the
// ultrasonic distance block and drives a motor command code and a PWM duty.
// When an obstacle is detected it runs a timed manoeuvre:
//   brake -> reverse -> turn -> settle -> re-check
// The manoeuvre uses distance hysteresis, alternates the turn direction and
// gives up after a fixed number of failed re-checks.
// Every output is registered and changes on the same edge as the state.

module avoidance_sequencer #(
  parameter int unsigned NEAR_TH     = 100,
  parameter int unsigned FAR_TH      = 120,
  parameter int unsigned BRAKE_CYC   = 5_000_000,
  parameter int unsigned REVERSE_CYC = 25_000_000,
  parameter int unsigned TURN_CYC    = 20_000_000,
  parameter int unsigned SETTLE_CYC  = 3_000_000,
  parameter int unsigned WDOG_CYC    = 10_000_000,
  parameter int unsigned MAX_TRIES   = 4,
  parameter int unsigned DUTY_FWD    = 255,
  parameter int unsigned DUTY_MAN    = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] distance,
  input  logic        dist_valid,
  output logic [3:0]  mode,
  output logic [7:0]  duty,
  output logic [3:0]  led,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRUISE  = 3'd1,
    S_BRAKE   = 3'd2,
    S_REVERSE = 3'd3,
    S_TURN    = 3'd4,
    S_SETTLE  = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // Thresholds and the last count value of each timed state.
  // A timed state leaves on the edge where its counter equals X_CYC-1,
  // so it stays for exactly X_CYC cycles.
  localparam logic [15:0] NEAR_V       = 16'(NEAR_TH);
  localparam logic [15:0] FAR_V        = 16'(FAR_TH);
  localparam logic [31:0] BRAKE_LAST   = 32'(BRAKE_CYC - 1);
  localparam logic [31:0] REVERSE_LAST = 32'(REVERSE_CYC - 1);
  localparam logic [31:0] TURN_LAST    = 32'(TURN_CYC - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] WDOG_LAST    = 32'(WDOG_CYC - 1);
  localparam logic [3:0]  TRIES_MAX    = 4'(MAX_TRIES);
  localparam logic [7:0]  DUTY_F       = 8'(DUTY_FWD);
  localparam logic [7:0]  DUTY_M       = 8'(DUTY_MAN);

  // Motor command codes.
  localparam logic [3:0] MODE_STOP  = 4'd0;
  localparam logic [3:0] MODE_FWD   = 4'd1;
  localparam logic [3:0] MODE_REV   = 4'd2;
  localparam logic [3:0] MODE_LEFT  = 4'd3;
  localparam logic [3:0] MODE_RIGHT = 4'd4;

  state_t      state_r;
  logic [31:0] dwell_r;        // cycles spent in the current timed state
  logic [31:0] wdog_r;         // cycles since the last sample (or since settle end)
  logic [3:0]  tries_r;        // consecutive failed re-checks
  logic        turn_dir_r;     // 0 = spin left, 1 = spin right
  logic        settle_done_r;  // settle blanking time has elapsed
  logic [3:0]  tries_inc_s;
  logic        obstacle_s;
  logic        clear_s;

  // Packed output word for a state: {mode, duty, led, busy}.
  function automatic logic [16:0] outs_for(input state_t st, input logic dir);
    logic [16:0] o;
    case (st)
      S_IDLE:    o = {MODE_STOP, 8'd0,   4'b0000, 1'b0};
      S_CRUISE:  o = {MODE_FWD,  DUTY_F, 4'b0001, 1'b0};
      S_BRAKE:   o = {MODE_STOP, 8'd0,   4'b0010, 1'b1};
      S_REVERSE: o = {MODE_REV,  DUTY_M, 4'b0010, 1'b1};
      S_TURN:    o = {(dir ? MODE_RIGHT : MODE_LEFT), DUTY_M, 4'b0100, 1'b1};
      S_SETTLE:  o = {MODE_STOP, 8'd0,   4'b0100, 1'b1};
      S_HALT:    o = {MODE_STOP, 8'd0,   4'b1000, 1'b0};
      default:   o = {MODE_STOP, 8'd0,   4'b0000, 1'b0};
    endcase
    return o;
  endfunction

  // Decode of the sampled distance against both thresholds, plus the next
  // value of the retry counter.
  always_comb begin
    tries_inc_s = tries_r + 4'd1;
    obstacle_s  = (distance <= NEAR_V);
    clear_s     = (distance > FAR_V);
  end

  // Main sequencer. It updates the state, all counters and the registered
  // outputs together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r                  <= S_IDLE;
      dwell_r                  <= 32'd0;
      wdog_r                   <= 32'd0;
      tries_r                  <= 4'd0;
      turn_dir_r               <= 1'b0;
      settle_done_r            <= 1'b0;
      {mode, duty, led, busy}  <= 17'd0;
    end else if (!enable) begin
      // A dropped run request aborts whatever is in progress.
      state_r                  <= S_IDLE;
      dwell_r                  <= 32'd0;
      wdog_r                   <= 32'd0;
      tries_r                  <= 4'd0;
      turn_dir_r               <= 1'b0;
      settle_done_r            <= 1'b0;
      {mode, duty, led, busy}  <= outs_for(S_IDLE, 1'b0);
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r                 <= S_CRUISE;
          dwell_r                 <= 32'd0;
          wdog_r                  <= 32'd0;
          tries_r                 <= 4'd0;
          turn_dir_r              <= 1'b0;
          settle_done_r           <= 1'b0;
          {mode, duty, led, busy} <= outs_for(S_CRUISE, 1'b0);
        end

        S_CRUISE: begin
          if (dist_valid) begin
            // A sample always restarts the watchdog, even on the expiry edge.
            wdog_r <= 32'd0;
            if (obstacle_s) begin
              state_r                 <= S_BRAKE;
              dwell_r                 <= 32'd0;
              {mode, duty, led, busy} <= outs_for(S_BRAKE, turn_dir_r);
            end
          end else if (wdog_r == WDOG_LAST) begin
            // Losing the sensor is treated the same as seeing an obstacle.
            state_r                 <= S_BRAKE;
            dwell_r                 <= 32'd0;
            wdog_r                  <= 32'd0;
            {mode, duty, led, busy} <= outs_for(S_BRAKE, turn_dir_r);
          end else begin
            wdog_r <= wdog_r + 32'd1;
          end
        end

        S_BRAKE: begin
          if (dwell_r == BRAKE_LAST) begin
            state_r                 <= S_REVERSE;
            dwell_r                 <= 32'd0;
            {mode, duty, led, busy} <= outs_for(S_REVERSE, turn_dir_r);
          end else begin
            dwell_r <= dwell_r + 32'd1;
          end
        end

        S_REVERSE: begin
          if (dwell_r == REVERSE_LAST) begin
            state_r                 <= S_TURN;
            dwell_r                 <= 32'd0;
            {mode, duty, led, busy} <= outs_for(S_TURN, turn_dir_r);
          end else begin
            dwell_r <= dwell_r + 32'd1;
          end
        end

        S_TURN: begin
          if (dwell_r == TURN_LAST) begin
            state_r                 <= S_SETTLE;
            dwell_r                 <= 32'd0;
            wdog_r                  <= 32'd0;
            settle_done_r           <= 1'b0;
            {mode, duty, led, busy} <= outs_for(S_SETTLE, turn_dir_r);
          end else begin
            dwell_r <= dwell_r + 32'd1;
          end
        end

        S_SETTLE: begin
          if (!settle_done_r) begin
            // Blanking: samples are ignored while the car comes to rest.
            if (dwell_r == SETTLE_LAST) begin
              settle_done_r <= 1'b1;
              wdog_r        <= 32'd0;
            end else begin
              dwell_r <= dwell_r + 32'd1;
            end
          end else if (dist_valid) begin
            if (clear_s) begin
              state_r                 <= S_CRUISE;
              tries_r                 <= 4'd0;
              wdog_r                  <= 32'd0;
              {mode, duty, led, busy} <= outs_for(S_CRUISE, turn_dir_r);
            end else if (tries_inc_s >= TRIES_MAX) begin
              // The retry counter saturates at the limit.
              state_r                 <= S_HALT;
              tries_r                 <= TRIES_MAX;
              turn_dir_r              <= ~turn_dir_r;
              {mode, duty, led, busy} <= outs_for(S_HALT, turn_dir_r);
            end else begin
              // Try again, turning the other way this time.
              state_r                 <= S_REVERSE;
              dwell_r                 <= 32'd0;
              tries_r                 <= tries_inc_s;
              turn_dir_r              <= ~turn_dir_r;
              {mode, duty, led, busy} <= outs_for(S_REVERSE, turn_dir_r);
            end
          end else if (wdog_r == WDOG_LAST) begin
            state_r                 <= S_HALT;
            {mode, duty, led, busy} <= outs_for(S_HALT, turn_dir_r);
          end else begin
            wdog_r <= wdog_r + 32'd1;
          end
        end

        S_HALT: begin
          // Only a dropped enable (or a reset) leaves HALT.
          state_r <= S_HALT;
        end

        default: begin
          state_r                 <= S_IDLE;
          dwell_r                 <= 32'd0;
          wdog_r                  <= 32'd0;
          tries_r                 <= 4'd0;
          turn_dir_r              <= 1'b0;
          settle_done_r           <= 1'b0;
          {mode, duty, led, busy} <= outs_for(S_IDLE, 1'b0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avoidance_sequencer.sv
// Testbench for avoidance_sequencer.
// The first part is a table of directed vectors covering the manoeuvre
// sequence. It is followed by hand-written sequences for:
//   - the cruise watchdog
//   - settle blanking and the settle watchdog
//   - an asynchronous reset
// The last part is randomized stimulus compared against a phase/elapsed-time
// reference model.

module tb_avoidance_sequencer;

  localparam int NEAR = 100;
  localparam int FAR  = 120;
  localparam int BRK  = 4;
  localparam int REV  = 8;
  localparam int TRN  = 6;
  localparam int SET  = 5;
  localparam int WDG  = 50;
  localparam int MAXT = 3;

  // Phase codes. Each one also selects an expected output set.
  localparam int P_IDLE   = 0;
  localparam int P_CRUISE = 1;
  localparam int P_BRAKE  = 2;
  localparam int P_REV    = 3;
  localparam int P_TURNL  = 4;
  localparam int P_TURNR  = 5;
  localparam int P_SETTLE = 6;
  localparam int P_HALT   = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        dist_valid;
  logic [15:0] distance;
  logic [3:0]  mode;
  logic [7:0]  duty;
  logic [3:0]  led;
  logic        busy;

  int errors = 0;
  int checks = 0;

  avoidance_sequencer #(
    .NEAR_TH(100), .FAR_TH(120), .BRAKE_CYC(4), .REVERSE_CYC(8),
    .TURN_CYC(6), .SETTLE_CYC(5), .WDOG_CYC(50), .MAX_TRIES(3),
    .DUTY_FWD(255), .DUTY_MAN(180)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .distance(distance),
    .dist_valid(dist_valid), .mode(mode), .duty(duty), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected outputs for each phase, as {mode, duty, led, busy}.
  function automatic logic [16:0] exp_of(input int p);
    logic [16:0] o;
    case (p)
      P_IDLE:   o = {4'd0, 8'd0,   4'b0000, 1'b0};
      P_CRUISE: o = {4'd1, 8'd255, 4'b0001, 1'b0};
      P_BRAKE:  o = {4'd0, 8'd0,   4'b0010, 1'b1};
      P_REV:    o = {4'd2, 8'd180, 4'b0010, 1'b1};
      P_TURNL:  o = {4'd3, 8'd180, 4'b0100, 1'b1};
      P_TURNR:  o = {4'd4, 8'd180, 4'b0100, 1'b1};
      P_SETTLE: o = {4'd0, 8'd0,   4'b0100, 1'b1};
      P_HALT:   o = {4'd0, 8'd0,   4'b1000, 1'b0};
      default:  o = 17'h1ffff;
    endcase
    return o;
  endfunction

  // Reference model state: current phase, edges spent in it, edges without
  // a sample, failed re-checks and the next turn direction.
  int m_ph;
  int m_time;
  int m_quiet;
  int m_tries;
  int m_dir;

  task automatic m_enter(input int ph);
    m_ph    = ph;
    m_time  = 0;
    m_quiet = 0;
  endtask

  task automatic m_reset();
    m_enter(P_IDLE);
    m_tries = 0;
    m_dir   = 0;
  endtask

  task automatic model_step(input int en, input int v, input int d);
    if (en == 0) begin
      m_reset();
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_reset();
          m_enter(P_CRUISE);
        end
        P_CRUISE: begin
          if (v != 0) begin
            m_quiet = 0;
            if (d <= NEAR) m_enter(P_BRAKE);
          end else begin
            m_quiet++;
            if (m_quiet == WDG) m_enter(P_BRAKE);
          end
        end
        P_BRAKE: begin
          m_time++;
          if (m_time == BRK) m_enter(P_REV);
        end
        P_REV: begin
          m_time++;
          if (m_time == REV) m_enter(m_dir != 0 ? P_TURNR : P_TURNL);
        end
        P_TURNL, P_TURNR: begin
          m_time++;
          if (m_time == TRN) m_enter(P_SETTLE);
        end
        P_SETTLE: begin
          m_time++;
          if (m_time > SET) begin
            if (v != 0) begin
              if (d > FAR) begin
                m_enter(P_CRUISE);
                m_tries = 0;
              end else begin
                m_tries++;
                m_dir = 1 - m_dir;
                if (m_tries >= MAXT) m_enter(P_HALT);
                else m_enter(P_REV);
              end
            end else begin
              m_quiet++;
              if (m_quiet == WDG) m_enter(P_HALT);
            end
          end
        end
        P_HALT: m_ph = P_HALT;
        default: m_reset();
      endcase
    end
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    checks++;
    if ({mode, duty, led, busy} !== exp) begin
      errors++;
      $display("FAIL %s: got mode=%0d duty=%0d led=%b busy=%b, expected mode=%0d duty=%0d led=%b busy=%b",
               name, mode, duty, led, busy, exp[16:13], exp[12:5], exp[4:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge and return at
  // the following falling edge, where the outputs are sampled.
  task automatic cycle(input int en, input int v, input int d);
    enable     = (en != 0);
    dist_valid = (v != 0);
    distance   = 16'(d);
    @(posedge clk);
    model_step(en, v, d);
    @(negedge clk);
  endtask

  typedef struct {
    int en;
    int v;
    int d;
    int p;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int en, input int v, input int d, input int p, input int n);
    vec_t r;
    for (int i = 0; i < n; i++) begin
      r.en = en; r.v = v; r.d = d; r.p = p;
      vecs.push_back(r);
    end
  endtask

  // Run time bound.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int vprob;
    int en;
    int v;
    int d;
    int k;
    rst_n = 1'b0; enable = 1'b0; dist_valid = 1'b0; distance = 16'd0;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset_state", exp_of(P_IDLE));
    enable = 1'b1;
    @(negedge clk);
    check("reset_with_enable", exp_of(P_IDLE));
    rst_n = 1'b1;

    // Directed table: each row gives one cycle of inputs and the phase
    // expected after that edge.
    add(0, 0, 0,   P_IDLE,   1);
    add(1, 0, 0,   P_CRUISE, 1);
    add(1, 1, 150, P_CRUISE, 1);
    add(1, 1, 110, P_CRUISE, 1);
    add(1, 1, 101, P_CRUISE, 1);
    add(1, 1, 100, P_BRAKE,  1);
    add(1, 0, 0,   P_BRAKE,  1);
    add(1, 1, 50,  P_BRAKE,  1);
    add(1, 0, 0,   P_BRAKE,  1);
    add(1, 0, 0,   P_REV,    1);
    add(1, 1, 30,  P_REV,    1);
    add(1, 0, 0,   P_REV,    6);
    add(1, 0, 0,   P_TURNL,  6);
    add(1, 0, 0,   P_SETTLE, 3);
    add(1, 1, 121, P_SETTLE, 1);
    add(1, 0, 0,   P_SETTLE, 2);
    add(1, 1, 121, P_CRUISE, 1);
    add(1, 1, 60,  P_BRAKE,  1);
    add(1, 0, 0,   P_BRAKE,  3);
    add(1, 0, 0,   P_REV,    8);
    add(1, 0, 0,   P_TURNL,  6);
    add(1, 0, 0,   P_SETTLE, 6);
    add(1, 1, 110, P_REV,    1);
    add(1, 0, 0,   P_REV,    7);
    add(1, 0, 0,   P_TURNR,  6);
    add(1, 0, 0,   P_SETTLE, 6);
    add(1, 1, 120, P_REV,    1);
    add(1, 0, 0,   P_REV,    7);
    add(1, 0, 0,   P_TURNL,  6);
    add(1, 0, 0,   P_SETTLE, 6);
    add(1, 1, 50,  P_HALT,   1);
    add(1, 1, 150, P_HALT,   2);
    add(0, 0, 0,   P_IDLE,   1);
    add(1, 0, 0,   P_CRUISE, 1);
    add(1, 1, 20,  P_BRAKE,  1);
    add(1, 0, 0,   P_BRAKE,  3);
    add(1, 0, 0,   P_REV,    8);
    add(1, 0, 0,   P_TURNL,  1);
    add(0, 0, 0,   P_IDLE,   1);
    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), exp_of(vecs[i].p));
    end

    // Cruise watchdog: a sample on the expiry edge wins; 50 quiet edges brake.
    cycle(1, 0, 0);
    repeat (49) cycle(1, 0, 0);
    check("wdog_49_quiet", exp_of(P_CRUISE));
    cycle(1, 1, 150);
    check("wdog_sample_wins", exp_of(P_CRUISE));
    repeat (49) cycle(1, 0, 0);
    check("wdog_49_again", exp_of(P_CRUISE));
    cycle(1, 0, 0);
    check("wdog_expire_brake", exp_of(P_BRAKE));

    // Reach SETTLE. Clear samples during blanking are ignored, then
    // 50 quiet edges halt.
    n = 0;
    while (m_ph != P_SETTLE && n < 40) begin
      cycle(1, 0, 0);
      n++;
    end
    check("reach_settle", exp_of(P_SETTLE));
    for (int i = 0; i < SET; i++) begin
      cycle(1, 1, 200);
      check($sformatf("settle_blank%0d", i), exp_of(P_SETTLE));
    end
    repeat (49) cycle(1, 0, 0);
    check("settle_wdog_49", exp_of(P_SETTLE));
    cycle(1, 0, 0);
    check("settle_wdog_halt", exp_of(P_HALT));

    // Reset asserted mid-REVERSE clears the outputs without waiting for a clock.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 10);
    repeat (3) cycle(1, 0, 0);
    repeat (2) cycle(1, 0, 0);
    check("pre_reset_reverse", exp_of(P_REV));
    rst_n = 1'b0;
    #1;
    check("async_reset", exp_of(P_IDLE));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0);
    check("post_reset_cruise", exp_of(P_CRUISE));

    // Randomized run checked against the reference model.
    vprob = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        k = int'($urandom_range(0, 3));
        vprob = (k == 0) ? 2 : (k == 1) ? 10 : (k == 2) ? 0 : 3;
      end
      en = ($urandom_range(0, 299) == 0) ? 0 : 1;
      v  = (vprob != 0 && $urandom_range(0, vprob - 1) == 0) ? 1 : 0;
      k  = int'($urandom_range(0, 5));
      case (k)
        0:       d = int'($urandom_range(0, 99));
        1:       d = 100;
        2:       d = int'($urandom_range(101, 120));
        3:       d = 120;
        4:       d = 121;
        default: d = int'($urandom_range(122, 1000));
      endcase
      cycle(en, v, d);
      check($sformatf("rand%0d", c), exp_of(m_ph));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avoidance_sequencer.md
# avoidance_sequencer

Obstacle-avoidance motion sequencer for the car. Consumes range samples from the ultrasonic distance block and drives a motor command code plus PWM duty to the four-wheel motor driver. Runs a timed brake → reverse → turn → settle → re-check manoeuvre with distance hysteresis, alternating turn direction and a retry limit. Sits between the distance detector and the motor PWM/direction logic.

## Interface
- NEAR_TH, 100: obstacle threshold, distance units (cm); obstacle when distance <= NEAR_TH
- FAR_TH, 120: clear threshold; path clear when distance > FAR_TH (must be > NEAR_TH)
- BRAKE_CYC, 5_000_000: BRAKE dwell in clk cycles
- REVERSE_CYC, 25_000_000: REVERSE dwell
- TURN_CYC, 20_000_000: TURN dwell
- SETTLE_CYC, 3_000_000: SETTLE blanking time
- WDOG_CYC, 10_000_000: max cycles without dist_valid before sensor-loss action
- MAX_TRIES, 4: consecutive failed re-checks before HALT (1..15)
- DUTY_FWD, 255: duty in CRUISE; DUTY_MAN, 180: duty in REVERSE/TURN
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- distance  in  16  latest range, valid only when dist_valid=1
- dist_valid  in  1  one-cycle strobe, new distance sample
- mode  out  4  motor command: 0 stop, 1 forward, 2 reverse, 3 spin left, 4 spin right
- duty  out  8  PWM duty for all motors
- led  out  4  status: [0] cruise, [1] brake/reverse, [2] turn/settle, [3] halt
- busy  out  1  high in any state other than IDLE/CRUISE/HALT

## Operation
- States: IDLE, CRUISE, BRAKE, REVERSE, TURN, SETTLE, HALT. One 32-bit dwell counter, one 32-bit watchdog counter, tries counter (4 bit), turn_dir flag (0=left).
- Priority each edge: reset > enable=0 (any state → IDLE) > state transitions.
- IDLE: mode 0, duty 0. enable=1 → CRUISE; tries, turn_dir, counters cleared.
- CRUISE: mode 1, duty DUTY_FWD. dist_valid with distance <= NEAR_TH → BRAKE. Watchdog reaching WDOG_CYC-1 with no dist_valid → BRAKE (sensor loss treated as obstacle). dist_valid restarts watchdog.
- BRAKE: mode 0, duty 0, dwell BRAKE_CYC → REVERSE.
- REVERSE: mode 2, duty DUTY_MAN, dwell REVERSE_CYC → TURN.
- TURN: mode 3 if turn_dir=0 else 4, duty DUTY_MAN, dwell TURN_CYC → SETTLE.
- SETTLE: mode 0, duty 0. dist_valid ignored until SETTLE_CYC elapsed; watchdog starts at settle end. First dist_valid after that: distance > FAR_TH → CRUISE, tries=0; otherwise tries+1, turn_dir toggled, → REVERSE, unless tries+1 == MAX_TRIES → HALT. Watchdog expiry after settle end → HALT.
- HALT: mode 0, duty 0, led[3]=1; exits only via enable=0 (→ IDLE).
- distance values in NEAR_TH+1..FAR_TH: no obstacle in CRUISE, not clear in SETTLE (hysteresis band).
- tries saturates at MAX_TRIES; turn_dir persists across CRUISE episodes, cleared only in IDLE/reset.

## Timing
- Reset (async assert, sync release): state IDLE, mode 0, duty 0, led 0000, busy 0, all counters 0, turn_dir 0.
- All outputs registered, updated on the same edge as state: input event sampled at edge k → new mode/duty/led visible after edge k (one-cycle latency).
- Timed states: counter cleared on entry; exit on the edge where counter == X_CYC-1, giving exactly X_CYC cycles in state.
- dist_valid coincident with watchdog expiry in CRUISE: the sample wins (obstacle check applies, watchdog restarts).
- dist_valid during BRAKE/REVERSE/TURN: ignored.
- enable deasserted mid-manoeuvre: IDLE on next edge, mode 0 immediately; no completion of dwell.
- Reset asserted mid-operation: outputs go to reset values asynchronously.

## Test plan
- Bench params: BRAKE 4, REVERSE 8, TURN 6, SETTLE 5, WDOG 50, MAX_TRIES 3.
- Reset low then enable=1 → mode 0 during reset, mode 1/duty 255 one cycle after enable sampled; distance 150 strobes keep CRUISE.
- CRUISE, strobe distance 100 → BRAKE (mode 0) 4 cycles, REVERSE (mode 2, duty 180) 8, TURN mode 3 for 6, SETTLE; strobe 121 → CRUISE, tries 0.
- Hysteresis: CRUISE strobe 110 → stays CRUISE; after manoeuvre, SETTLE strobe 110 → REVERSE, next TURN mode 4.
- Three failed re-checks (strobe 50 each SETTLE) → HALT, led=1000, mode 0; enable=0 → IDLE; enable=1 → CRUISE, first turn mode 3.
- No dist_valid for 50 cycles in CRUISE → BRAKE; strobe during SETTLE blanking ignored; reset asserted mid-REVERSE → outputs zero immediately.
